cnn_axil_ctrl_slave: RTL
========================

Name: cnn_axil_ctrl_slave

Overview:
AXI4-Lite slave control/status register block for the CNN accelerator, directly downstream of the XDMA peripheral interconnect's M00 AXI4-Lite port (64-bit address, 32-bit data). It converts host register accesses into an ap_ctrl-style start/done handshake with the kernel, scalar argument registers and a level interrupt. One outstanding read and one outstanding write at a time.

Parameters:
ADDR_WIDTH, 64, width of S_AXI_awaddr/araddr
DEC_BITS, 8, low address bits decoded; upper bits ignored
NUM_ARGS, 4, number of 32-bit scalar argument registers (1..48)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_awaddr  in  ADDR_WIDTH  write address
S_AXI_awvalid / S_AXI_awready  in/out  1  AW handshake
S_AXI_wdata  in  32  write data
S_AXI_wstrb  in  4  byte strobes
S_AXI_wvalid / S_AXI_wready  in/out  1  W handshake
S_AXI_bresp  out  2  write response
S_AXI_bvalid / S_AXI_bready  out/in  1  B handshake
S_AXI_araddr  in  ADDR_WIDTH  read address
S_AXI_arvalid / S_AXI_arready  in/out  1  AR handshake
S_AXI_rdata  out  32  read data
S_AXI_rresp  out  2  read response
S_AXI_rvalid / S_AXI_rready  out/in  1  R handshake
ap_start  out  1  kernel start
ap_done  in  1  kernel done pulse
ap_idle  in  1  kernel idle level
ap_ready  in  1  kernel ready pulse
args  out  32*NUM_ARGS  arg i at [32i+31:32i]
interrupt  out  1  level interrupt

Behaviour:
- Reset (async assert, sync release): every output and register 0; awready/wready/arready first go 1 the cycle after ARESETN rises. Reset mid-transaction aborts it; bvalid/rvalid drop immediately.
- Map (addr[DEC_BITS-1:2], addr[1:0] ignored): 0x00 CTRL {bit7 auto_restart RW, bit3 ap_ready RO, bit2 ap_idle RO, bit1 ap_done COR, bit0 ap_start RW1S}; 0x04 GIE bit0; 0x08 IER bits[1:0]; 0x0C ISR bits[1:0] (bit0 done, bit1 ready), write-1-toggles; 0x10+4i ARG i RW. Unmapped: writes dropped, reads 0.
- Write FSM W_IDLE -> W_RESP: AW and W accepted independently, any order or same cycle; each ready drops once its beat is latched. When both held: register update applied with wstrb per byte, bvalid=1, bresp=OKAY next cycle. W_RESP holds bvalid until bready, then both readies reassert next cycle.
- Read FSM R_IDLE -> R_DATA: arready=1 in idle; on handshake rdata/rresp registered, rvalid=1 next cycle (1-cycle latency); held stable until rready; arready returns next cycle.
- ap_start: set by write CTRL bit0=1 (wstrb[0]); cleared on ap_ready pulse unless auto_restart=1. Writing 0 has no effect.
- ap_done bit: set on ap_done pulse; cleared by CTRL read handshake; simultaneous set and read-clear -> bit stays 1, read returns pre-event value.
- ISR bit n set on event when IER[n]=1; simultaneous event and toggle-write -> bit ends 1.
- interrupt registered: GIE[0] & |ISR, 1-cycle delay.
- Simultaneous read and write to same register: read returns pre-write value.

Optional Feature:
CNN_AXIL_ERR_RESP_EN: defined -> unmapped address, or address bits above DEC_BITS non-zero, returns SLVERR (2'b10) on bresp/rresp, rdata 0, no state change. Undefined -> OKAY everywhere, unmapped reads 0, writes ignored.

Test Plan:
- Release reset -> all outputs 0 during reset; awready=wready=arready=1 one cycle after release; read 0x00 returns 0x0 (ap_idle=0).
- W beat 3 cycles before AW to 0x10, data 0xDEADBEEF, wstrb 4'b0101 -> bvalid one cycle after AW, args[31:0]=0x00AD00EF; read 0x10 -> rdata 0x00AD00EF one cycle after AR.
- Write CTRL=0x1, IER=0x1, GIE=0x1; pulse ap_ready then ap_done -> ap_start falls cycle after ap_ready; interrupt=1 two cycles after ap_done; read CTRL returns bit1=1, second read bit1=0; write ISR=0x1 -> interrupt 0.
- CTRL=0x81, pulse ap_ready -> ap_start stays 1; clear auto_restart, pulse ap_ready -> ap_start 0.
- Hold bready=0 10 cycles, rready=0 10 cycles -> bvalid/rvalid, rdata stable; awready/arready stay 0 until release.
- Read 0xF0 and write 0x1_0000_0000 -> with macro SLVERR, rdata 0; without, OKAY, no register change.

Source files
------------

// File: rtl/cnn_axil_ctrl_slave.sv
// AXI4-Lite control/status slave for the CNN kernel: ap_ctrl start/done
// handshake, scalar argument registers and a level interrupt.
// Optional build macro: CNN_AXIL_ERR_RESP_EN (SLVERR on unmapped accesses).
//
// state  | meaning
// W_IDLE | collecting AW and W beats, either order
// W_RESP | write applied, holding bvalid until bready
// R_IDLE | arready high, waiting for an address
// R_DATA | rdata/rresp held, waiting for rready
module cnn_axil_ctrl_slave #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEC_BITS   = 8,
  parameter int NUM_ARGS   = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_awaddr,
  input  logic                     S_AXI_awvalid,
  output logic                     S_AXI_awready,
  input  logic [31:0]              S_AXI_wdata,
  input  logic [3:0]               S_AXI_wstrb,
  input  logic                     S_AXI_wvalid,
  output logic                     S_AXI_wready,
  output logic [1:0]               S_AXI_bresp,
  output logic                     S_AXI_bvalid,
  input  logic                     S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_araddr,
  input  logic                     S_AXI_arvalid,
  output logic                     S_AXI_arready,
  output logic [31:0]              S_AXI_rdata,
  output logic [1:0]               S_AXI_rresp,
  output logic                     S_AXI_rvalid,
  input  logic                     S_AXI_rready,
  output logic                     ap_start,
  input  logic                     ap_done,
  input  logic                     ap_idle,
  input  logic                     ap_ready,
  output logic [32*NUM_ARGS-1:0]   args,
  output logic                     interrupt
);

  localparam int IDX_W = DEC_BITS - 2;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  aw_held, w_held, aw_held_d, w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_take, w_take, ar_take, wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_bad, rd_bad, wr_ok;
  logic [31:0]           rd_word;

  logic                  auto_restart, done_bit, gie;
  logic [1:0]            ier, isr;
  logic [32*NUM_ARGS-1:0] args_q;
  logic                  unused_addr_bits;

  assign aw_take = S_AXI_awvalid && S_AXI_awready;
  assign w_take  = S_AXI_wvalid && S_AXI_wready;
  assign ar_take = S_AXI_arvalid && S_AXI_arready;

  // A beat captured in an earlier cycle takes precedence over the live bus.
  assign wr_addr = aw_held ? aw_addr_q : S_AXI_awaddr;
  assign wr_data = w_held ? wdata_q : S_AXI_wdata;
  assign wr_strb = w_held ? wstrb_q : S_AXI_wstrb;
  assign wr_idx  = wr_addr[DEC_BITS-1:2];
  assign rd_idx  = S_AXI_araddr[DEC_BITS-1:2];

`ifdef CNN_AXIL_ERR_RESP_EN
  assign wr_bad = (wr_addr[ADDR_WIDTH-1:DEC_BITS] != '0) || (int'(wr_idx) >= 4 + NUM_ARGS);
  assign rd_bad = (S_AXI_araddr[ADDR_WIDTH-1:DEC_BITS] != '0) || (int'(rd_idx) >= 4 + NUM_ARGS);
`else
  assign wr_bad = 1'b0;
  assign rd_bad = 1'b0;
`endif

  assign unused_addr_bits = ^{wr_addr[ADDR_WIDTH-1:DEC_BITS], wr_addr[1:0],
                              S_AXI_araddr[ADDR_WIDTH-1:DEC_BITS], S_AXI_araddr[1:0]};

  assign wr_ok        = wr_en && !wr_bad;
  assign S_AXI_bvalid = (w_state == W_RESP);
  assign S_AXI_rvalid = (r_state == R_DATA);
  assign args         = args_q;

  // FSM state registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Next-state and beat-holding decisions for both channels
  always_comb begin
    w_next    = w_state;
    r_next    = r_state;
    wr_en     = 1'b0;
    aw_held_d = 1'b0;
    w_held_d  = 1'b0;
    case (w_state)
      W_IDLE: begin
        wr_en     = (aw_held || aw_take) && (w_held || w_take);
        aw_held_d = (aw_held || aw_take) && !wr_en;
        w_held_d  = (w_held || w_take) && !wr_en;
        if (wr_en) w_next = W_RESP;
      end
      W_RESP: if (S_AXI_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_take) r_next = R_DATA;
      R_DATA:  if (S_AXI_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Handshake readies, captured beats and response registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_awready <= 1'b0;
      S_AXI_wready  <= 1'b0;
      S_AXI_arready <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      S_AXI_bresp   <= 2'b00;
      S_AXI_rdata   <= '0;
      S_AXI_rresp   <= 2'b00;
    end else begin
      aw_held       <= aw_held_d;
      w_held        <= w_held_d;
      S_AXI_awready <= (w_next == W_IDLE) && !aw_held_d;
      S_AXI_wready  <= (w_next == W_IDLE) && !w_held_d;
      S_AXI_arready <= (r_next == R_IDLE);
      if (aw_take) aw_addr_q <= S_AXI_awaddr;
      if (w_take) begin
        wdata_q <= S_AXI_wdata;
        wstrb_q <= S_AXI_wstrb;
      end
      if (wr_en) S_AXI_bresp <= wr_bad ? 2'b10 : 2'b00;
      if (ar_take) begin
        S_AXI_rdata <= rd_word;
        S_AXI_rresp <= rd_bad ? 2'b10 : 2'b00;
      end
    end
  end

  // Read mux; sees register values before any same-cycle write
  always_comb begin
    rd_word = '0;
    case (int'(rd_idx))
      0: rd_word = {24'b0, auto_restart, 3'b0, ap_ready, ap_idle, done_bit, ap_start};
      1: rd_word = {31'b0, gie};
      2: rd_word = {30'b0, ier};
      3: rd_word = {30'b0, isr};
      default: begin
        for (int i = 0; i < NUM_ARGS; i++)
          if (int'(rd_idx) == 4 + i) rd_word = args_q[32*i +: 32];
      end
    endcase
    if (rd_bad) rd_word = '0;
  end

  // Control, interrupt and argument registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
      done_bit     <= 1'b0;
      gie          <= 1'b0;
      ier          <= 2'b00;
      isr          <= 2'b00;
      interrupt    <= 1'b0;
      args_q       <= '0;
    end else begin
      // set from the host wins over a same-cycle clear from the kernel
      if (wr_ok && int'(wr_idx) == 0 && wr_strb[0] && wr_data[0]) ap_start <= 1'b1;
      else if (ap_ready && !auto_restart)                           ap_start <= 1'b0;
      if (wr_ok && int'(wr_idx) == 0 && wr_strb[0]) auto_restart <= wr_data[7];

      if (ap_done)                                                done_bit <= 1'b1;
      else if (ar_take && !rd_bad && int'(rd_idx) == 0)           done_bit <= 1'b0;

      if (wr_ok && int'(wr_idx) == 1 && wr_strb[0]) gie <= wr_data[0];
      if (wr_ok && int'(wr_idx) == 2 && wr_strb[0]) ier <= wr_data[1:0];
      // toggle first, then OR in events so a coincident event is never lost
      isr <= (isr ^ ((wr_ok && int'(wr_idx) == 3 && wr_strb[0]) ? wr_data[1:0] : 2'b00))
             | ({ap_ready, ap_done} & ier);
      interrupt <= gie && (isr != 2'b00);

      for (int i = 0; i < NUM_ARGS; i++)
        for (int b = 0; b < 4; b++)
          if (wr_ok && int'(wr_idx) == 4 + i && wr_strb[b])
            args_q[32*i + 8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule
